// File: rtl/channel_sampler_pkg.sv
// Shared definitions for channel_sampler: register map, FSM encoding,
// entry layout and the channel-scan helper.
package channel_sampler_pkg;

    localparam logic [15:0] REG_CTRL   = 16'd0;
    localparam logic [15:0] REG_MASK   = 16'd1;
    localparam logic [15:0] REG_PERIOD = 16'd2;

    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_FLUSH_BIT = 1;
    localparam int CTRL_CLEAR_BIT = 2;

    localparam logic [7:0] MARKER_ID = 8'hFF;
    localparam int         CH_ID_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    function automatic int entry_width(input int data_width);
        return CH_ID_W + data_width;
    endfunction

    // Lowest set bit of mask at or above start; bit 5 of the result flags a hit.
    function automatic logic [5:0] first_set_from(input logic [31:0] mask, input logic [5:0] start);
        logic [5:0] res;
        res = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                res = {1'b1, 5'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// First-word-fall-through ring buffer with occupancy count and a drop pulse
// for writes refused because the buffer is full.
module sample_ring_buffer #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_rd_s;
    logic             do_wr_s;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    // A pop frees the slot for a same-cycle push, so full only blocks writes without rd_en.
    assign do_rd_s = rd_en_i & ~empty_o & ~flush_i;
    assign do_wr_s = wr_en_i & (~full_o | rd_en_i) & ~flush_i;
    assign drop_o  = wr_en_i & full_o & ~rd_en_i & ~flush_i;

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr_s) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd_s) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_wr_s} - {{AW{1'b0}}, do_rd_s};
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr_s) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/channel_sampler.sv
// Periodic multi-channel sampler: scans enabled channels each prescaler tick
// and queues {channel id, sample}. Define SAMPLER_TIMESTAMP_EN for per-round time markers.
module channel_sampler
    import channel_sampler_pkg::*;
#(
    parameter int          NUM_CHANNELS = 8,
    parameter int          DATA_WIDTH   = 16,
    parameter int          FIFO_DEPTH   = 512,
    parameter logic [15:0] BASE_ADDR    = 16'd200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   addr,
    input  logic [31:0]                   cmd_data_in,
    input  logic                          cs,
    input  logic                          wr,
    input  logic [31:0]                   current_time,
    output logic                          output_sample,
    output logic [7:0]                    channel_select,
    input  logic [DATA_WIDTH-1:0]         sample_data,
    input  logic                          sample_fifo_rd_en,
    output logic [CH_ID_W+DATA_WIDTH-1:0] sample_data_out,
    output logic                          sample_fifo_empty,
    output logic                          sample_fifo_full,
    output logic [15:0]                   sample_fifo_data_count,
    output logic [15:0]                   drop_count,
    output logic                          late
);
    localparam int          ENTRY_W     = entry_width(DATA_WIDTH);
    localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + REG_CTRL;
    localparam logic [15:0] ADDR_MASK   = BASE_ADDR + REG_MASK;
    localparam logic [15:0] ADDR_PERIOD = BASE_ADDR + REG_PERIOD;

    logic                    wr_acc_s, ctrl_wr_s, flush_s, clear_s;
    logic                    tick_s, start_s, mark_s, buf_wr_s, drop_s;
    logic [5:0]              first_s, next_s;
    logic [ENTRY_W-1:0]      buf_data_s;
    logic [CNT_W-1:0]        count_s;
    logic                    unused_s;
    logic                    run_q;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [31:0]             period_q, presc_q, presc_d;
    state_e                  state_q;
    logic [31:0]             round_mask_q;
    logic [4:0]              ptr_q;
    logic                    output_sample_q;
    logic [7:0]              channel_select_q;
    logic [15:0]             drop_q;
    logic                    late_q;

    assign wr_acc_s  = cs & wr;
    assign ctrl_wr_s = wr_acc_s & (addr == ADDR_CTRL);
    assign flush_s   = ctrl_wr_s & cmd_data_in[CTRL_FLUSH_BIT];
    assign clear_s   = ctrl_wr_s & cmd_data_in[CTRL_CLEAR_BIT];
    assign tick_s    = run_q & (presc_q == 32'd0);
    assign first_s   = first_set_from(32'(mask_q), 6'd0);
    assign next_s    = first_set_from(round_mask_q, {1'b0, ptr_q} + 6'd1);
    assign start_s   = tick_s & (state_q == ST_IDLE) & first_s[5] & ~flush_s;
    assign unused_s  = ^current_time;

`ifdef SAMPLER_TIMESTAMP_EN
    assign mark_s = start_s;
`else
    assign mark_s = 1'b0;
`endif

    assign buf_wr_s   = (state_q == ST_CAPTURE) | mark_s;
    assign buf_data_s = mark_s ? {MARKER_ID, current_time[DATA_WIDTH-1:0]}
                               : {3'b000, ptr_q, sample_data};

    // Prescaler next value: held at period while stopped, reloaded after each tick.
    always_comb begin
        if (!run_q || (presc_q == 32'd0)) begin
            presc_d = period_q;
        end else begin
            presc_d = presc_q - 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            mask_q   <= '0;
            period_q <= 32'd0;
            presc_q  <= 32'd0;
        end else begin
            presc_q <= presc_d;
            if (ctrl_wr_s) run_q <= cmd_data_in[CTRL_RUN_BIT];
            if (wr_acc_s && (addr == ADDR_MASK)) mask_q <= cmd_data_in[NUM_CHANNELS-1:0];
            if (wr_acc_s && (addr == ADDR_PERIOD)) period_q <= cmd_data_in;
        end
    end

    // Scan FSM; the round mask is frozen at round start so mid-round mask writes wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            round_mask_q     <= 32'd0;
            ptr_q            <= 5'd0;
            output_sample_q  <= 1'b0;
            channel_select_q <= 8'd0;
        end else if (flush_s) begin
            state_q         <= ST_IDLE;
            output_sample_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        round_mask_q     <= 32'(mask_q);
                        ptr_q            <= first_s[4:0];
                        channel_select_q <= {3'b000, first_s[4:0]};
                        output_sample_q  <= 1'b1;
                        state_q          <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    output_sample_q <= 1'b0;
                    state_q         <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (next_s[5]) begin
                        ptr_q            <= next_s[4:0];
                        channel_select_q <= {3'b000, next_s[4:0]};
                        output_sample_q  <= 1'b1;
                        state_q          <= ST_SELECT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    output_sample_q <= 1'b0;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 16'd0;
            late_q <= 1'b0;
        end else if (clear_s) begin
            drop_q <= 16'd0;
            late_q <= 1'b0;
        end else begin
            if (drop_s && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
            if (tick_s && (state_q != ST_IDLE)) late_q <= 1'b1;
        end
    end

    sample_ring_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_s),
        .wr_en_i   (buf_wr_s),
        .wr_data_i (buf_data_s),
        .rd_en_i   (sample_fifo_rd_en),
        .rd_data_o (sample_data_out),
        .empty_o   (sample_fifo_empty),
        .full_o    (sample_fifo_full),
        .count_o   (count_s),
        .drop_o    (drop_s)
    );

    assign output_sample          = output_sample_q;
    assign channel_select         = channel_select_q;
    assign sample_fifo_data_count = 16'(count_s);
    assign drop_count             = drop_q;
    assign late                   = late_q;

endmodule

// File: tb/tb_channel_sampler.sv
// Self-checking bench for channel_sampler: round-schedule/queue reference model
// compared every cycle, plus hand-computed checks of the key scenarios.
module tb_channel_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'd0;
    logic [31:0] cmd_data_in = 32'd0;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] current_time = 32'h0001_0000;
    logic        output_sample;
    logic [7:0]  channel_select;
    logic [15:0] sample_data;
    logic        rd_en = 1'b0;
    logic [23:0] data_out;
    logic        empty, full;
    logic [15:0] dcount, drop;
    logic        late;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    channel_sampler #(
        .NUM_CHANNELS (8),
        .DATA_WIDTH   (16),
        .FIFO_DEPTH   (4),
        .BASE_ADDR    (16'd200)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .addr                   (addr),
        .cmd_data_in            (cmd_data_in),
        .cs                     (cs),
        .wr                     (wr),
        .current_time           (current_time),
        .output_sample          (output_sample),
        .channel_select         (channel_select),
        .sample_data            (sample_data),
        .sample_fifo_rd_en      (rd_en),
        .sample_data_out        (data_out),
        .sample_fifo_empty      (empty),
        .sample_fifo_full       (full),
        .sample_fifo_data_count (dcount),
        .drop_count             (drop),
        .late                   (late)
    );

    // A channel only answers correctly once the request has been withdrawn.
    assign sample_data = output_sample ? 16'hDEAD : {8'h5A, channel_select};

    always @(negedge clk) current_time = current_time + 32'd1;

    // Reference model: a round started at cycle rs selects its k-th channel at rs+1+2k
    // and stores it at the end of rs+2+2k; the buffer is a plain queue of depth 4.
    bit          m_run;
    logic [7:0]  m_mask;
    int          m_period, run_cyc, t, rs, n_ch, last_ch, m_drop;
    int          chs[8];
    bit          m_late;
    bit          chk_en = 1'b0;
    logic [23:0] q[$];

    function automatic bit in_round(input int tc);
        return (n_ch > 0) && (tc >= rs + 1) && (tc <= rs + 2 * n_ch);
    endfunction

    initial begin
        t = 0; rs = 0; n_ch = 0; last_ch = 0; m_drop = 0; m_late = 1'b0;
        m_run = 1'b0; m_mask = 8'd0; m_period = 0; run_cyc = 0;
    end

    always @(posedge clk) begin : model
        bit          tick, inr, wr_acc, flush_b, clr_b, wr_req, rd_b, full_b;
        int          idx;
        logic [23:0] ent;
        if (rst) begin
            m_run = 1'b0; m_mask = 8'd0; m_period = 0; run_cyc = 0;
            n_ch = 0; last_ch = 0; m_drop = 0; m_late = 1'b0;
            q.delete();
        end else begin
            inr  = in_round(t);
            tick = 1'b0;
            if (m_run) begin
                tick = ((run_cyc % (m_period + 1)) == m_period);
                run_cyc++;
            end else begin
                run_cyc = 0;
            end
            wr_acc  = cs && wr;
            flush_b = wr_acc && (addr == 16'd200) && cmd_data_in[1];
            clr_b   = wr_acc && (addr == 16'd200) && cmd_data_in[2];
            wr_req  = 1'b0;
            ent     = 24'd0;
            if (inr) begin
                idx     = (t - rs - 1) / 2;
                last_ch = chs[idx];
                if (((t - rs - 1) % 2) == 1) begin
                    wr_req = 1'b1;
                    ent    = {8'(chs[idx]), 8'h5A, 8'(chs[idx])};
                end
            end
`ifdef SAMPLER_TIMESTAMP_EN
            if (tick && !inr && (m_mask != 8'd0) && !flush_b) begin
                wr_req = 1'b1;
                ent    = {8'hFF, current_time[15:0]};
            end
`endif
            full_b = (q.size() == 4);
            if (flush_b) begin
                q.delete();
            end else begin
                rd_b = rd_en && (q.size() > 0);
                if (rd_b) void'(q.pop_front());
                if (wr_req) begin
                    if (!full_b || rd_b) q.push_back(ent);
                    else if (m_drop != 16'hFFFF) m_drop++;
                end
            end
            if (tick && inr) m_late = 1'b1;
            if (clr_b) begin
                m_late = 1'b0;
                m_drop = 0;
            end
            if (flush_b) begin
                n_ch = 0;
            end else if (tick && !inr && (m_mask != 8'd0)) begin
                rs   = t;
                n_ch = 0;
                for (int i = 0; i < 8; i++) begin
                    if (m_mask[i]) begin
                        chs[n_ch] = i;
                        n_ch++;
                    end
                end
            end
            if (wr_acc && (addr == 16'd200)) m_run = cmd_data_in[0];
            if (wr_acc && (addr == 16'd201)) m_mask = cmd_data_in[7:0];
            if (wr_acc && (addr == 16'd202)) m_period = int'(cmd_data_in);
        end
        t++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    always @(negedge clk) begin : compare
        bit          ir;
        int          idx;
        logic [23:0] exp_head;
        if (chk_en && !rst) begin
            ir       = in_round(t);
            idx      = ir ? (t - rs - 1) / 2 : 0;
            exp_head = (q.size() > 0) ? q[0] : 24'h0;
            chk("cyc_output_sample", 32'(output_sample), 32'(ir && (((t - rs - 1) % 2) == 0)));
            chk("cyc_channel_select", 32'(channel_select), ir ? chs[idx] : last_ch);
            chk("cyc_head", 32'(data_out), 32'(exp_head));
            chk("cyc_count", 32'(dcount), q.size());
            chk("cyc_empty", 32'(empty), 32'(q.size() == 0));
            chk("cyc_full", 32'(full), 32'(q.size() == 4));
            chk("cyc_drop", 32'(drop), m_drop);
            chk("cyc_late", 32'(late), 32'(m_late));
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; cmd_data_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic wait_os(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (output_sample) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no output_sample within 200 cycles", name);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_output_sample"}, 32'(output_sample), 32'd0);
        chk({tag, "_channel_select"}, 32'(channel_select), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_count"}, 32'(dcount), 32'd0);
        chk({tag, "_drop"}, 32'(drop), 32'd0);
        chk({tag, "_late"}, 32'(late), 32'd0);
        chk({tag, "_head"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        int os_t[3];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_values("reset");
        chk_en = 1'b1;

        // Two enabled channels, period 9: pulses two cycles apart, rounds ten apart.
        bus_write(16'd202, 32'd9);
        bus_write(16'd201, 32'h0000_0005);
        bus_write(16'd200, 32'd1);
        for (int p = 0; p < 3; p++) begin
            wait_os("pulse_timing");
            os_t[p] = t;
        end
        chk("pulse_gap", 32'(os_t[1] - os_t[0]), 32'd2);
        chk("round_gap", 32'(os_t[2] - os_t[0]), 32'd10);
        bus_write(16'd200, 32'd0);
        repeat (4) @(negedge clk);
        chk("two_rounds_head", 32'(data_out), 32'h0000_5A00);
        chk("two_rounds_count", 32'(dcount), 32'd4);
        chk("two_rounds_drop", 32'(drop), 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("pop_head", 32'(data_out), 32'h0002_5A02);
        chk("pop_count", 32'(dcount), 32'd3);

        // Three channels into a 4-deep buffer without reads.
        bus_write(16'd200, 32'd2);
        chk("flush_empty", 32'(empty), 32'd1);
        bus_write(16'd201, 32'h0000_0007);
        bus_write(16'd200, 32'd1);
        repeat (6) wait_os("overflow_rounds");
        repeat (2) @(negedge clk);
        chk("overflow_count", 32'(dcount), 32'd4);
        chk("overflow_drop", 32'(drop), 32'd2);
        chk("overflow_full", 32'(full), 32'd1);
        wait_os("full_rw_round");
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("full_rw_count", 32'(dcount), 32'd4);
        chk("full_rw_head", 32'(data_out), 32'h0001_5A01);
        chk("full_rw_drop", 32'(drop), 32'd2);
        bus_write(16'd200, 32'd2);

        // Flush in the middle of an eight-channel round.
        bus_write(16'd201, 32'h0000_00FF);
        bus_write(16'd200, 32'd1);
        wait_os("flush_round");
        @(negedge clk);
        bus_write(16'd200, 32'd3);
        chk("midflush_empty", 32'(empty), 32'd1);
        chk("midflush_output_sample", 32'(output_sample), 32'd0);
        repeat (12) @(negedge clk);
        bus_write(16'd200, 32'd0);
        repeat (20) @(negedge clk);

        // Period 0 with four channels: ticks land inside the round.
        rd_en = 1'b1;
        bus_write(16'd202, 32'd0);
        bus_write(16'd201, 32'h0000_000F);
        bus_write(16'd200, 32'd1);
        repeat (12) @(negedge clk);
        chk("late_set", 32'(late), 32'd1);
        bus_write(16'd200, 32'd4);
        repeat (10) @(negedge clk);
        chk("late_cleared", 32'(late), 32'd0);

        // Asynchronous reset while a capture is in progress.
        rd_en = 1'b0;
        bus_write(16'd200, 32'd1);
        repeat (12) @(negedge clk);
        wait_os("reset_round");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("after_reset_idle", 32'(output_sample), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
